// File: rtl/condicionador_botoes.sv
// Button conditioner: sync, shared-counter debounce, one-hot validation.
// Emits a registered play code plus a one-cycle pulse per accepted press.
module condicionador_botoes #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       habilitar,
    input  logic       limpar,
    input  logic [3:0] botoes,
    output logic [3:0] jogada,
    output logic       jogada_feita,
    output logic       multipla,
    output logic [1:0] db_estado,
    output logic [3:0] db_estavel
);

    localparam int CW_RAW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int CW     = (CW_RAW < 1) ? 1 : CW_RAW;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        OCIOSO        = 2'd0,
        REGISTRA      = 2'd1,
        MULTIPLA      = 2'd2,
        ESPERA_SOLTAR = 2'd3
    } estado_t;

    logic [3:0]    s1, s2, candidato, estavel;
    logic [CW-1:0] cnt;
    estado_t       estado, prox_estado;
    logic          carrega;
    logic          vazio, varios;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1 <= 4'b0000;
            s2 <= 4'b0000;
        end else begin
            s1 <= botoes;
            s2 <= s1;
        end
    end

    // cnt saturates at CNT_MAX so a held pattern never re-triggers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            candidato <= 4'b0000;
            cnt       <= '0;
            estavel   <= 4'b0000;
        end else if (s2 != candidato) begin
            candidato <= s2;
            cnt       <= '0;
        end else if (cnt == CNT_MAX) begin
            estavel <= candidato;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign vazio  = (estavel == 4'b0000);
    assign varios = |(estavel & (estavel - 4'd1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado <= OCIOSO;
        end else begin
            estado <= prox_estado;
        end
    end

    always_comb begin
        prox_estado = estado;
        carrega     = 1'b0;
        unique case (estado)
            OCIOSO: begin
                if (vazio) begin
                    prox_estado = OCIOSO;
                end else if (varios) begin
                    prox_estado = MULTIPLA;
                end else if (habilitar) begin
                    prox_estado = REGISTRA;
                    carrega     = 1'b1;
                end else begin
                    prox_estado = ESPERA_SOLTAR;
                end
            end
            REGISTRA:      prox_estado = ESPERA_SOLTAR;
            MULTIPLA:      prox_estado = ESPERA_SOLTAR;
            ESPERA_SOLTAR: prox_estado = vazio ? OCIOSO : ESPERA_SOLTAR;
            default:       prox_estado = OCIOSO;
        endcase
    end

    // a load on the same edge as limpar takes priority
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            jogada <= 4'b0000;
        end else if (carrega) begin
            jogada <= estavel;
        end else if (limpar) begin
            jogada <= 4'b0000;
        end
    end

    assign jogada_feita = (estado == REGISTRA);
    assign multipla     = (estado == MULTIPLA);
    assign db_estado    = estado;
    assign db_estavel   = estavel;

endmodule

// File: tb/tb_condicionador_botoes.sv
// Directed bench for condicionador_botoes with DEBOUNCE_CYCLES = 4.
// Edge 0 is the first rising edge after a new botoes value is driven.
module tb_condicionador_botoes;

    logic       clock = 1'b0;
    logic       reset;
    logic       habilitar;
    logic       limpar;
    logic [3:0] botoes;
    logic [3:0] jogada;
    logic       jogada_feita;
    logic       multipla;
    logic [1:0] db_estado;
    logic [3:0] db_estavel;

    int checks   = 0;
    int failures = 0;

    condicionador_botoes #(.DEBOUNCE_CYCLES(4)) dut (
        .clock        (clock),
        .reset        (reset),
        .habilitar    (habilitar),
        .limpar       (limpar),
        .botoes       (botoes),
        .jogada       (jogada),
        .jogada_feita (jogada_feita),
        .multipla     (multipla),
        .db_estado    (db_estado),
        .db_estavel   (db_estavel)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // drive b before edge 0, sample after each of n edges
    task automatic run_edges(input int n, input logic [3:0] b,
                             output int np, output int first,
                             output int nm, output logic [3:0] est_or);
        np = 0; first = -1; nm = 0; est_or = 4'b0000;
        botoes = b;
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            @(negedge clock);
            if (jogada_feita) begin
                if (np == 0) first = i;
                np++;
            end
            if (multipla) nm++;
            est_or |= db_estavel;
        end
    endtask

    int np, first, nm;
    logic [3:0] eo;
    logic [1:0] st [0:15];

    initial begin
        reset = 1'b0; habilitar = 1'b1; limpar = 1'b0; botoes = 4'b0100;
        repeat (3) @(negedge clock);
        chk("rst_jogada", jogada, 4'b0000);
        chk("rst_feita", jogada_feita, 1'b0);
        chk("rst_mult", multipla, 1'b0);
        chk("rst_estado", db_estado, 2'd0);
        chk("rst_estavel", db_estavel, 4'b0000);
        reset = 1'b1;
        run_edges(12, 4'b0100, np, first, nm, eo);
        chk("rst_np", np, 1);
        chk("rst_first", first, 7);
        chk("rst_jog", jogada, 4'b0100);
        run_edges(12, 4'b0000, np, first, nm, eo);

        run_edges(20, 4'b0010, np, first, nm, eo);
        chk("p2_np", np, 1);
        chk("p2_first", first, 7);
        chk("p2_jog", jogada, 4'b0010);
        run_edges(12, 4'b0000, np, first, nm, eo);
        chk("p2_rel_np", np, 0);
        chk("p2_rel_jog", jogada, 4'b0010);
        chk("p2_rel_est", db_estado, 2'd0);

        run_edges(3, 4'b1000, np, first, nm, eo);
        chk("gl_np_a", np, 0);
        chk("gl_est_a", eo, 4'b0000);
        run_edges(12, 4'b0000, np, first, nm, eo);
        chk("gl_np_b", np, 0);
        chk("gl_est_b", eo, 4'b0000);
        chk("gl_jog", jogada, 4'b0010);

        np = 0; first = -1;
        for (int i = 0; i < 30; i++) begin
            botoes = (i < 10 && ((i / 2) % 2) == 1) ? 4'b0000 : 4'b0001;
            @(posedge clock);
            @(negedge clock);
            if (jogada_feita) begin
                if (np == 0) first = i;
                np++;
            end
        end
        chk("bn_np", np, 1);
        chk("bn_first", first, 15);
        chk("bn_jog", jogada, 4'b0001);
        run_edges(12, 4'b0000, np, first, nm, eo);

        np = 0; nm = 0;
        botoes = 4'b0101;
        for (int i = 0; i < 16; i++) begin
            @(posedge clock);
            @(negedge clock);
            st[i] = db_estado;
            if (jogada_feita) np++;
            if (multipla) nm++;
        end
        chk("mu_nm", nm, 1);
        chk("mu_np", np, 0);
        chk("mu_st6", st[6], 2'd0);
        chk("mu_st7", st[7], 2'd2);
        chk("mu_st8", st[8], 2'd3);
        chk("mu_st15", st[15], 2'd3);
        chk("mu_jog", jogada, 4'b0001);
        run_edges(12, 4'b0000, np, first, nm, eo);
        chk("mu_idle", db_estado, 2'd0);

        habilitar = 1'b0;
        run_edges(10, 4'b0001, np, first, nm, eo);
        chk("hb_np_a", np, 0);
        chk("hb_est", db_estado, 2'd3);
        habilitar = 1'b1;
        run_edges(10, 4'b0001, np, first, nm, eo);
        chk("hb_np_b", np, 0);
        run_edges(12, 4'b0000, np, first, nm, eo);
        chk("hb_np_c", np, 0);
        run_edges(12, 4'b0001, np, first, nm, eo);
        chk("hb_np_d", np, 1);
        chk("hb_first", first, 7);
        chk("hb_jog", jogada, 4'b0001);
        limpar = 1'b1;
        @(posedge clock);
        #1 limpar = 1'b0;
        @(negedge clock);
        chk("lp_jog", jogada, 4'b0000);
        run_edges(12, 4'b0000, np, first, nm, eo);
        chk("lp_np", np, 0);
        chk("lp_jog2", jogada, 4'b0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
